io_port_fabric: RTL and testbench

Parametrised IO-space bus fabric that sits between the CPU memory port and up to NUM_PORTS peripherals, replacing fixed-decode, fixed-latency port muxing with a request/acknowledge transaction per access. The top SLOT_BITS of the address select a peripheral slot. The fabric issues a one-cycle strobe to that slot, waits for that peripheral's acknowledge, and returns registered read data together with a ready pulse. Accesses to absent slots, and accesses that are never acknowledged, complete with a bus error instead of hanging the CPU.

---
 rtl/io_port_fabric.sv | 168 ++++++++++++++++
 tb/tb_io_port_fabric.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_fabric.sv
// IO-space bus fabric: decodes a slot from the upper address bits, issues a one-cycle
// strobe, waits for that slot's acknowledge (or a timeout) and returns a ready pulse.
module io_port_fabric #(
    parameter int              BITS           = 16,
    parameter int              ADDRESS_BITS   = 16,
    parameter int              SLOT_BITS      = 4,
    parameter int              NUM_PORTS      = 10,
    parameter int              TIMEOUT_CYCLES = 255,
    parameter logic [BITS-1:0] ERR_VALUE      = 16'hDEAD
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [ADDRESS_BITS-1:0]        ADDRESS,
    input  logic [BITS-1:0]                DATA_IN,
    output logic [BITS-1:0]                DATA_OUT,
    input  logic                           memWR,
    input  logic                           memRD,
    output logic                           memREADY,
    output logic                           bus_err,
    output logic [ADDRESS_BITS-1:0]        err_addr,
    output logic [ADDRESS_BITS-SLOT_BITS-1:0] port_addr,
    output logic [BITS-1:0]                port_wdata,
    output logic [NUM_PORTS-1:0]           port_wr,
    output logic [NUM_PORTS-1:0]           port_rd,
    input  logic [NUM_PORTS*BITS-1:0]      port_rdata,
    input  logic [NUM_PORTS-1:0]           port_ack
);

    localparam int OFF_BITS = ADDRESS_BITS - SLOT_BITS;
    localparam int CNT_BITS = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(TIMEOUT_CYCLES);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic                    is_wr_q, is_wr_d;
    logic [SLOT_BITS-1:0]    slot_q, slot_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic                    err_q, err_d;
    logic [CNT_BITS-1:0]     cnt_q, cnt_d;
    logic [BITS-1:0]         dout_q, dout_d;
    logic [ADDRESS_BITS-1:0] err_addr_q, err_addr_d;
    logic [OFF_BITS-1:0]     port_addr_q, port_addr_d;
    logic [BITS-1:0]         port_wdata_q, port_wdata_d;

    logic [SLOT_BITS-1:0] slot_in;
    logic                 slot_mapped;
    logic                 ack_sel;
    logic [BITS-1:0]      rdata_sel;
    logic [NUM_PORTS-1:0] slot_onehot;
    logic [CNT_BITS-1:0]  cnt_inc;

    assign slot_in     = ADDRESS[ADDRESS_BITS-1 -: SLOT_BITS];
    assign slot_mapped = 32'(slot_in) < 32'(NUM_PORTS);

    // Only the captured slot's ack and read data are ever looked at.
    always_comb begin
        ack_sel     = 1'b0;
        rdata_sel   = '0;
        slot_onehot = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (slot_q == SLOT_BITS'(k)) begin
                ack_sel        = port_ack[k];
                rdata_sel      = port_rdata[k*BITS +: BITS];
                slot_onehot[k] = 1'b1;
            end
        end
    end

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_BITS'(1);

    always_comb begin
        state_d      = state_q;
        is_wr_d      = is_wr_q;
        slot_d       = slot_q;
        addr_d       = addr_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        err_addr_d   = err_addr_q;
        port_addr_d  = port_addr_q;
        port_wdata_d = port_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (memWR || memRD) begin
                    is_wr_d      = memWR;
                    slot_d       = slot_in;
                    addr_d       = ADDRESS;
                    port_addr_d  = ADDRESS[OFF_BITS-1:0];
                    port_wdata_d = DATA_IN;
                    if (slot_mapped) begin
                        err_d   = 1'b0;
                        state_d = StIssue;
                    end else begin
                        err_d      = 1'b1;
                        err_addr_d = ADDRESS;
                        if (!memWR) dout_d = ERR_VALUE;
                        state_d    = StDone;
                    end
                end
            end
            StIssue: begin
                cnt_d = '0;
                if (ack_sel) begin
                    if (!is_wr_q) dout_d = rdata_sel;
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_inc;
                // Ack takes priority over a timeout landing in the same cycle.
                if (ack_sel) begin
                    if (!is_wr_q) dout_d = rdata_sel;
                    state_d = StDone;
                end else if (TIMEOUT_CYCLES != 0 && cnt_inc == CNT_MAX) begin
                    err_d      = 1'b1;
                    err_addr_d = addr_q;
                    if (!is_wr_q) dout_d = ERR_VALUE;
                    state_d    = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            is_wr_q      <= 1'b0;
            slot_q       <= '0;
            addr_q       <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            dout_q       <= '0;
            err_addr_q   <= '0;
            port_addr_q  <= '0;
            port_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            is_wr_q      <= is_wr_d;
            slot_q       <= slot_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            err_addr_q   <= err_addr_d;
            port_addr_q  <= port_addr_d;
            port_wdata_q <= port_wdata_d;
        end
    end

    assign DATA_OUT   = dout_q;
    assign err_addr   = err_addr_q;
    assign port_addr  = port_addr_q;
    assign port_wdata = port_wdata_q;
    assign memREADY   = (state_q == StDone);
    assign bus_err    = memREADY && err_q;
    assign port_wr    = (state_q == StIssue && is_wr_q)  ? slot_onehot : '0;
    assign port_rd    = (state_q == StIssue && !is_wr_q) ? slot_onehot : '0;

endmodule

// File: tb/tb_io_port_fabric.sv
// Self-checking bench for io_port_fabric: directed scenarios plus randomized traffic
// compared against a transaction-level model of slot decode, ack latency and timeout.
module tb_io_port_fabric;

    localparam int NP = 10;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [15:0]   ADDRESS = '0;
    logic [15:0]   DATA_IN = '0;
    logic [15:0]   DATA_OUT;
    logic          memWR = 1'b0;
    logic          memRD = 1'b0;
    logic          memREADY;
    logic          bus_err;
    logic [15:0]   err_addr;
    logic [11:0]   port_addr;
    logic [15:0]   port_wdata;
    logic [NP-1:0] port_wr;
    logic [NP-1:0] port_rd;
    logic [NP*16-1:0] port_rdata = '0;
    logic [NP-1:0] port_ack = '0;

    io_port_fabric #(
        .BITS(16), .ADDRESS_BITS(16), .SLOT_BITS(4), .NUM_PORTS(NP),
        .TIMEOUT_CYCLES(TO), .ERR_VALUE(16'hDEAD)
    ) dut (
        .CLK(CLK), .RST(RST), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
        .memWR(memWR), .memRD(memRD), .memREADY(memREADY), .bus_err(bus_err),
        .err_addr(err_addr), .port_addr(port_addr), .port_wdata(port_wdata),
        .port_wr(port_wr), .port_rd(port_rd), .port_rdata(port_rdata), .port_ack(port_ack)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0]    rdy;
        logic          err;
        logic [3:0]    n_wr;
        logic [NP-1:0] wr_bits;
        logic [3:0]    n_rd;
        logic [NP-1:0] rd_bits;
        logic [15:0]   dout;
        logic [15:0]   eaddr;
        logic [11:0]   paddr;
        logic [15:0]   pwdata;
    } txn_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_dout = '0;
    logic [15:0] exp_err_addr = '0;

    // Transaction-level model: ready cycle counted from the sampling cycle.
    task automatic predict(input logic [15:0] addr, input logic [15:0] wdata, input logic wr,
                           input int ack_n, input logic [15:0] rdata, output txn_t e);
        int slot;
        slot     = int'(addr[15:12]);
        e        = '0;
        e.paddr  = addr[11:0];
        e.pwdata = wdata;
        if (slot >= NP) begin
            e.rdy = 8'd1;
            e.err = 1'b1;
            exp_err_addr = addr;
            if (!wr) exp_dout = 16'hDEAD;
        end else begin
            if (wr) begin e.n_wr = 4'd1; e.wr_bits[slot] = 1'b1; end
            else    begin e.n_rd = 4'd1; e.rd_bits[slot] = 1'b1; end
            if (ack_n >= 0 && ack_n <= TO) begin
                e.rdy = 8'(2 + ack_n);
                if (!wr) exp_dout = rdata;
            end else begin
                e.rdy = 8'(TO + 2);
                e.err = 1'b1;
                exp_err_addr = addr;
                if (!wr) exp_dout = 16'hDEAD;
            end
        end
        e.dout  = exp_dout;
        e.eaddr = exp_err_addr;
    endtask

    // Drives one CPU access plus a peripheral that acks ack_n cycles after the strobe
    // (or every cycle when hold is set); other slots ack and return data at random.
    task automatic drive_txn(input logic [15:0] addr, input logic [15:0] wdata,
                             input logic wr, input logic rd, input int ack_n, input bit hold,
                             input logic [15:0] rdata, output txn_t o);
        int slot;
        bit done;
        logic [NP-1:0] acks;
        slot  = int'(addr[15:12]);
        o     = '0;
        o.rdy = 8'hFF;
        done  = 1'b0;
        for (int c = 0; c < 32 && !done; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                ADDRESS = addr; DATA_IN = wdata; memWR = wr; memRD = rd;
            end else begin
                ADDRESS = 16'($urandom); DATA_IN = 16'($urandom);
            end
            acks = NP'($urandom);
            if (slot < NP) begin
                acks[slot] = hold || (ack_n >= 0 && c == 1 + ack_n);
            end
            port_ack = acks;
            for (int k = 0; k < NP; k++) begin
                port_rdata[k*16 +: 16] = (k == slot) ? rdata : 16'($urandom);
            end
            #1;
            if (port_wr != '0) begin o.n_wr = o.n_wr + 4'd1; o.wr_bits |= port_wr; end
            if (port_rd != '0) begin o.n_rd = o.n_rd + 4'd1; o.rd_bits |= port_rd; end
            if (memREADY) begin
                o.rdy = 8'(c); o.err = bus_err; o.dout = DATA_OUT; o.eaddr = err_addr;
                o.paddr = port_addr; o.pwdata = port_wdata;
                memWR = 1'b0; memRD = 1'b0;
                done  = 1'b1;
            end
        end
        memWR = 1'b0; memRD = 1'b0;
    endtask

    task automatic test_reset;
        ADDRESS = 16'h3004; memRD = 1'b1; port_ack = '1;
        repeat (3) @(negedge CLK);
        #1;
        if ({memREADY, bus_err, port_wr, port_rd} !== '0) begin
            $display("FAIL reset_ctrl: got %b want 0", {memREADY, bus_err, port_wr, port_rd});
            n_bad++;
        end
        n_cmp++;
        if ({DATA_OUT, err_addr, port_addr, port_wdata} !== '0) begin
            $display("FAIL reset_regs: got %h want 0", {DATA_OUT, err_addr, port_addr, port_wdata});
            n_bad++;
        end
        n_cmp++;
        @(negedge CLK);
        RST = 1'b0; memRD = 1'b0; port_ack = '0;
    endtask

    task automatic test_read_fast;
        txn_t e, o;
        predict(16'h3004, 16'h0000, 1'b0, 0, 16'h1234, e);
        drive_txn(16'h3004, 16'h0000, 1'b0, 1'b1, 0, 1'b1, 16'h1234, o);
        if (o !== e) begin $display("FAIL read_fast: got %p want %p", o, e); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_write_delay;
        txn_t e, o;
        predict(16'h7010, 16'hBEEF, 1'b1, 5, 16'h0000, e);
        drive_txn(16'h7010, 16'hBEEF, 1'b1, 1'b0, 5, 1'b0, 16'h0000, o);
        if (o !== e) begin $display("FAIL write_delay: got %p want %p", o, e); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_unmapped;
        txn_t e, o;
        predict(16'hC000, 16'h0000, 1'b0, 0, 16'h0000, e);
        drive_txn(16'hC000, 16'h0000, 1'b0, 1'b1, 0, 1'b1, 16'h0000, o);
        if (o !== e) begin $display("FAIL unmapped: got %p want %p", o, e); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_timeout;
        txn_t e, o;
        predict(16'h2008, 16'h0000, 1'b0, -1, 16'h4321, e);
        drive_txn(16'h2008, 16'h0000, 1'b0, 1'b1, -1, 1'b0, 16'h4321, o);
        if (o !== e) begin $display("FAIL timeout: got %p want %p", o, e); n_bad++; end
        n_cmp++;
        predict(16'h200C, 16'h0000, 1'b0, TO, 16'h5A5A, e);
        drive_txn(16'h200C, 16'h0000, 1'b0, 1'b1, TO, 1'b0, 16'h5A5A, o);
        if (o !== e) begin $display("FAIL ack_on_timeout: got %p want %p", o, e); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_both_requests;
        txn_t e, o;
        predict(16'h1000, 16'h7777, 1'b1, 2, 16'h9999, e);
        drive_txn(16'h1000, 16'h7777, 1'b1, 1'b1, 2, 1'b0, 16'h9999, o);
        if (o !== e) begin $display("FAIL wr_and_rd: got %p want %p", o, e); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_reset_mid;
        txn_t e, o;
        bit seen;
        @(negedge CLK);
        ADDRESS = 16'h2040; DATA_IN = 16'h5555; memRD = 1'b1; port_ack = '0;
        repeat (2) @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1; memRD = 1'b0;
        seen = 1'b0;
        for (int c = 4; c < 16; c++) begin
            @(negedge CLK);
            RST = 1'b0;
            port_ack = NP'(1 << 2);
            #1;
            if (memREADY || bus_err || port_wr != '0 || port_rd != '0) seen = 1'b1;
            if (c == 4) begin
                if ({DATA_OUT, err_addr, port_addr, port_wdata} !== '0) begin
                    $display("FAIL reset_mid_regs: got %h want 0",
                             {DATA_OUT, err_addr, port_addr, port_wdata});
                    n_bad++;
                end
                n_cmp++;
            end
        end
        if (seen !== 1'b0) begin
            $display("FAIL reset_mid_quiet: got activity %b want 0", seen); n_bad++;
        end
        n_cmp++;
        port_ack = '0;
        exp_dout = '0; exp_err_addr = '0;
        predict(16'h2044, 16'h0000, 1'b0, 1, 16'hCAFE, e);
        drive_txn(16'h2044, 16'h0000, 1'b0, 1'b1, 1, 1'b0, 16'hCAFE, o);
        if (o !== e) begin $display("FAIL after_reset: got %p want %p", o, e); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_back_to_back;
        txn_t e, o;
        logic [15:0] a, d;
        for (int i = 0; i < 4; i++) begin
            a = {4'($urandom_range(0, NP - 1)), 12'($urandom)};
            d = 16'($urandom);
            predict(a, d, i[0], 0, d ^ 16'h0F0F, e);
            drive_txn(a, d, i[0], ~i[0], 0, 1'b1, d ^ 16'h0F0F, o);
            if (o !== e) begin $display("FAIL back_to_back%0d: got %p want %p", i, o, e); n_bad++; end
            n_cmp++;
        end
    endtask

    task automatic test_random;
        txn_t e, o;
        logic [15:0] a, d, r;
        logic wr, rd;
        int ack_n, mode;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) a = {4'($urandom_range(NP, 15)), 12'($urandom)};
            else                           a = {4'($urandom_range(0, NP - 1)), 12'($urandom)};
            d     = 16'($urandom);
            r     = 16'($urandom);
            mode  = $urandom_range(0, 2);
            wr    = (mode != 0);
            rd    = (mode != 1);
            ack_n = $urandom_range(0, 11);
            if (ack_n > 9) ack_n = -1;
            predict(a, d, wr, ack_n, r, e);
            drive_txn(a, d, wr, rd, ack_n, 1'b0, r, o);
            if (o !== e) begin $display("FAIL random%0d: got %p want %p", i, o, e); n_bad++; end
            n_cmp++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_fast();
        test_write_delay();
        test_unmapped();
        test_timeout();
        test_both_requests();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
